pic_rw_ctrl_seq: RTL and testbench

//  Clocked, parametrised read/write control for the 8259-style PIC. Decodes CPU bus writes into
//  the ICW1..ICW4 init sequence and OCW1..OCW3 operational words. Serves register reads
//  (IRR/ISR/IMR/poll word). Sits between the CPU bus pins and the priority/in-service logic.

---
 rtl/pic_rw_ctrl_seq_pkg.sv | 59 +++++
 rtl/pic_rw_ctrl_seq_bus_strobe.sv | 63 ++++++
 rtl/pic_rw_ctrl_seq.sv | 266 ++++++++++++++++++++++++++
 tb/tb_pic_rw_ctrl_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pic_rw_ctrl_seq_pkg.sv
// ---------------------------------------------------------------------------
// pic_pkg
//   Shared definitions for the 8259-style PIC read/write control slice:
//   sequencer state encodings, ICW/OCW bit positions and next-state helpers
//   for the initialisation word sequence.
// ---------------------------------------------------------------------------
package pic_pkg;

  typedef logic [2:0] pic_state_t;

  // Sequencer states
  localparam logic [2:0] ST_UNINIT    = 3'd0;
  localparam logic [2:0] ST_WAIT_ICW2 = 3'd1;
  localparam logic [2:0] ST_WAIT_ICW3 = 3'd2;
  localparam logic [2:0] ST_WAIT_ICW4 = 3'd3;
  localparam logic [2:0] ST_READY     = 3'd4;

  // ICW1 bit positions
  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_ID   = 4;

  // OCW3 bit positions
  localparam int OCW3_RIS  = 0;
  localparam int OCW3_RR   = 1;
  localparam int OCW3_P    = 2;
  localparam int OCW3_SMM  = 5;
  localparam int OCW3_ESMM = 6;

  // a0=0 word selector: 0 -> OCW2, 1 -> OCW3 (when bit ICW1_ID is clear)
  localparam int OCW_SEL   = 3;

  // State following ICW2: ICW3 only exists in cascade mode
  function automatic pic_state_t next_after_icw2(input logic cascade_en,
                                                 input logic sngl,
                                                 input logic ic4);
    pic_state_t st;
    if (cascade_en && !sngl) begin
      st = ST_WAIT_ICW3;
    end else if (ic4) begin
      st = ST_WAIT_ICW4;
    end else begin
      st = ST_READY;
    end
    return st;
  endfunction

  // State following ICW3
  function automatic pic_state_t next_after_icw3(input logic ic4);
    pic_state_t st;
    if (ic4) begin
      st = ST_WAIT_ICW4;
    end else begin
      st = ST_READY;
    end
    return st;
  endfunction

endpackage

// File: rtl/pic_rw_ctrl_seq_bus_strobe.sv
// ---------------------------------------------------------------------------
// pic_bus_strobe
//   Captures a0/d_in/cs_n on every cycle the write strobe is low and emits
//   single-cycle strobes for the end of a write and the end of a read.
// Ports
//   clk, rst_n          clock, async active-low reset
//   cs_n, wr_n, rd_n    bus control (already synchronous to clk)
//   a0, d_in            bus address bit and write data
//   wr_a0, wr_d         address/data captured during the last write low phase
//   wr_commit           1 on the first cycle wr_n is high after being low,
//                       only when chip select was active at capture
//   rd_end              1 on the first cycle rd_n is high after a selected read
// ---------------------------------------------------------------------------
module pic_bus_strobe #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs_n,
  input  logic          wr_n,
  input  logic          rd_n,
  input  logic          a0,
  input  logic [DW-1:0] d_in,
  output logic          wr_a0,
  output logic [DW-1:0] wr_d,
  output logic          wr_commit,
  output logic          rd_end
);

  logic          r_wr_low;
  logic          r_cs_n_cap;
  logic          r_a0_cap;
  logic [DW-1:0] r_d_cap;
  logic          r_rd_low;

  // Write-phase capture and read-phase tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_low   <= 1'b0;
      r_cs_n_cap <= 1'b1;
      r_a0_cap   <= 1'b0;
      r_d_cap    <= '0;
      r_rd_low   <= 1'b0;
    end else begin
      if (!wr_n) begin
        r_wr_low   <= 1'b1;
        r_cs_n_cap <= cs_n;
        r_a0_cap   <= a0;
        r_d_cap    <= d_in;
      end else begin
        r_wr_low   <= 1'b0;
      end
      // A write in progress suppresses the read, so it never ends a read
      r_rd_low <= !cs_n && !rd_n && wr_n;
    end
  end

  assign wr_a0     = r_a0_cap;
  assign wr_d      = r_d_cap;
  assign wr_commit = r_wr_low && wr_n && !r_cs_n_cap;
  assign rd_end    = r_rd_low && rd_n;

endmodule

// File: rtl/pic_rw_ctrl_seq.sv
// ---------------------------------------------------------------------------
// pic_rw_ctrl_seq
//   Read/write control for an 8259-style PIC. Decodes CPU bus writes into the
//   ICW1..ICW4 initialisation sequence and OCW1..OCW3 operational words, and
//   serves IRR/ISR/IMR/poll-word reads.
// Ports
//   clk, rst_n              clock, async active-low reset
//   cs_n, wr_n, rd_n, a0    CPU bus control; d_in write data
//   d_out, d_oe             registered read data and output enable
//   irr_i, isr_i, poll_vec_i  read sources from request/priority logic
//   icw1_o..icw4_o          latched init words
//   init_pulse              1 clk when ICW1 is accepted
//   init_done               init sequence complete
//   imr_o                   interrupt mask (OCW1)
//   ocw2_o, ocw2_stb        last OCW2 and its 1-clk strobe
//   smm_o                   special mask mode
//   poll_ack                1 clk when a poll read completes
//   seq_err                 1 clk when a write is dropped as illegal
// ---------------------------------------------------------------------------
module pic_rw_ctrl_seq
  import pic_pkg::*;
#(
  parameter int DW         = 8,
  parameter int CASCADE_EN = 1,
  parameter int RR_DEFAULT = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs_n,
  input  logic          wr_n,
  input  logic          rd_n,
  input  logic          a0,
  input  logic [DW-1:0] d_in,
  output logic [DW-1:0] d_out,
  output logic          d_oe,
  input  logic [DW-1:0] irr_i,
  input  logic [DW-1:0] isr_i,
  input  logic [DW-1:0] poll_vec_i,
  output logic [DW-1:0] icw1_o,
  output logic [DW-1:0] icw2_o,
  output logic [DW-1:0] icw3_o,
  output logic [DW-1:0] icw4_o,
  output logic          init_pulse,
  output logic          init_done,
  output logic [DW-1:0] imr_o,
  output logic [DW-1:0] ocw2_o,
  output logic          ocw2_stb,
  output logic          smm_o,
  output logic          poll_ack,
  output logic          seq_err
);

  localparam logic LP_CASCADE = (CASCADE_EN != 0) ? 1'b1 : 1'b0;
  localparam logic LP_RR_RST  = (RR_DEFAULT != 0) ? 1'b1 : 1'b0;

  logic          w_wr_a0;
  logic [DW-1:0] w_wr_d;
  logic          w_wr_commit;
  logic          w_rd_end;
  logic          w_rd_act;
  logic [DW-1:0] w_rd_data;

  pic_state_t    r_state,     w_state_nx;
  logic [DW-1:0] r_icw1,      w_icw1_nx;
  logic [DW-1:0] r_icw2,      w_icw2_nx;
  logic [DW-1:0] r_icw3,      w_icw3_nx;
  logic [DW-1:0] r_icw4,      w_icw4_nx;
  logic [DW-1:0] r_imr,       w_imr_nx;
  logic [DW-1:0] r_ocw2,      w_ocw2_nx;
  logic          r_init_done, w_init_done_nx;
  logic          r_init_pulse, w_init_pulse_nx;
  logic          r_ocw2_stb,  w_ocw2_stb_nx;
  logic          r_seq_err,   w_seq_err_nx;
  logic          r_smm,       w_smm_nx;
  logic          r_rr_sel,    w_rr_sel_nx;
  logic          r_poll_pend, w_poll_pend_nx;
  logic          r_poll_ack,  w_poll_ack_nx;
  logic          r_d_oe;
  logic [DW-1:0] r_d_out;

  pic_bus_strobe #(.DW(DW)) u_strobe (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs_n      (cs_n),
    .wr_n      (wr_n),
    .rd_n      (rd_n),
    .a0        (a0),
    .d_in      (d_in),
    .wr_a0     (w_wr_a0),
    .wr_d      (w_wr_d),
    .wr_commit (w_wr_commit),
    .rd_end    (w_rd_end)
  );

  // Write decode and sequencer next-state
  always_comb begin
    w_state_nx      = r_state;
    w_icw1_nx       = r_icw1;
    w_icw2_nx       = r_icw2;
    w_icw3_nx       = r_icw3;
    w_icw4_nx       = r_icw4;
    w_imr_nx        = r_imr;
    w_ocw2_nx       = r_ocw2;
    w_smm_nx        = r_smm;
    w_rr_sel_nx     = r_rr_sel;
    w_poll_pend_nx  = r_poll_pend;
    w_init_pulse_nx = 1'b0;
    w_ocw2_stb_nx   = 1'b0;
    w_seq_err_nx    = 1'b0;
    w_poll_ack_nx   = 1'b0;

    // A completed read while a poll is pending consumes the poll
    if (w_rd_end && r_poll_pend) begin
      w_poll_pend_nx = 1'b0;
      w_poll_ack_nx  = 1'b1;
    end else begin
      w_poll_ack_nx  = 1'b0;
    end

    if (w_wr_commit) begin
      // ICW1 restarts the sequence from any state
      if (!w_wr_a0 && w_wr_d[ICW1_ID]) begin
        w_icw1_nx       = w_wr_d;
        w_icw2_nx       = '0;
        w_icw3_nx       = '0;
        w_icw4_nx       = '0;
        w_imr_nx        = '0;
        w_init_pulse_nx = 1'b1;
        w_state_nx      = ST_WAIT_ICW2;
      end else begin
        case (r_state)
          ST_WAIT_ICW2: begin
            if (w_wr_a0) begin
              w_icw2_nx  = w_wr_d;
              w_state_nx = next_after_icw2(LP_CASCADE, r_icw1[ICW1_SNGL],
                                           r_icw1[ICW1_IC4]);
            end else begin
              w_seq_err_nx = 1'b1;
            end
          end
          ST_WAIT_ICW3: begin
            if (w_wr_a0) begin
              w_icw3_nx  = w_wr_d;
              w_state_nx = next_after_icw3(r_icw1[ICW1_IC4]);
            end else begin
              w_seq_err_nx = 1'b1;
            end
          end
          ST_WAIT_ICW4: begin
            if (w_wr_a0) begin
              w_icw4_nx  = w_wr_d;
              w_state_nx = ST_READY;
            end else begin
              w_seq_err_nx = 1'b1;
            end
          end
          ST_READY: begin
            if (w_wr_a0) begin
              w_imr_nx = w_wr_d;
            end else if (!w_wr_d[OCW_SEL]) begin
              w_ocw2_nx     = w_wr_d;
              w_ocw2_stb_nx = 1'b1;
            end else begin
              // OCW3: each field only applies when its enable bit is set
              if (w_wr_d[OCW3_RR]) begin
                w_rr_sel_nx = w_wr_d[OCW3_RIS];
              end else begin
                w_rr_sel_nx = r_rr_sel;
              end
              if (w_wr_d[OCW3_ESMM]) begin
                w_smm_nx = w_wr_d[OCW3_SMM];
              end else begin
                w_smm_nx = r_smm;
              end
              if (w_wr_d[OCW3_P]) begin
                w_poll_pend_nx = 1'b1;
              end else begin
                w_poll_pend_nx = r_poll_pend;
              end
            end
          end
          default: begin
            // UNINIT (and any unreachable encoding) only accepts ICW1
            w_seq_err_nx = 1'b1;
            w_state_nx   = ST_UNINIT;
          end
        endcase
      end
    end else begin
      w_state_nx = r_state;
    end

    // Only READY is initialised; ICW1 always leaves READY
    w_init_done_nx = (w_state_nx == ST_READY);
  end

  // Control and configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_UNINIT;
      r_icw1       <= '0;
      r_icw2       <= '0;
      r_icw3       <= '0;
      r_icw4       <= '0;
      r_imr        <= '0;
      r_ocw2       <= '0;
      r_init_done  <= 1'b0;
      r_init_pulse <= 1'b0;
      r_ocw2_stb   <= 1'b0;
      r_seq_err    <= 1'b0;
      r_smm        <= 1'b0;
      r_rr_sel     <= LP_RR_RST;
      r_poll_pend  <= 1'b0;
      r_poll_ack   <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_icw1       <= w_icw1_nx;
      r_icw2       <= w_icw2_nx;
      r_icw3       <= w_icw3_nx;
      r_icw4       <= w_icw4_nx;
      r_imr        <= w_imr_nx;
      r_ocw2       <= w_ocw2_nx;
      r_init_done  <= w_init_done_nx;
      r_init_pulse <= w_init_pulse_nx;
      r_ocw2_stb   <= w_ocw2_stb_nx;
      r_seq_err    <= w_seq_err_nx;
      r_smm        <= w_smm_nx;
      r_rr_sel     <= w_rr_sel_nx;
      r_poll_pend  <= w_poll_pend_nx;
      r_poll_ack   <= w_poll_ack_nx;
    end
  end

  // Read source select; a pending poll overrides the addressed register
  assign w_rd_act  = !cs_n && !rd_n && wr_n;
  assign w_rd_data = r_poll_pend ? poll_vec_i :
                     a0          ? r_imr      :
                     r_rr_sel    ? isr_i      : irr_i;

  // Registered read data and bus drive enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_oe  <= 1'b0;
      r_d_out <= '0;
    end else begin
      r_d_oe  <= w_rd_act;
      r_d_out <= w_rd_act ? w_rd_data : '0;
    end
  end

  assign d_out      = r_d_out;
  assign d_oe       = r_d_oe;
  assign icw1_o     = r_icw1;
  assign icw2_o     = r_icw2;
  assign icw3_o     = r_icw3;
  assign icw4_o     = r_icw4;
  assign init_pulse = r_init_pulse;
  assign init_done  = r_init_done;
  assign imr_o      = r_imr;
  assign ocw2_o     = r_ocw2;
  assign ocw2_stb   = r_ocw2_stb;
  assign smm_o      = r_smm;
  assign poll_ack   = r_poll_ack;
  assign seq_err    = r_seq_err;

endmodule

// File: tb/tb_pic_rw_ctrl_seq.sv
module tb_pic_rw_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n, cs_n, wr_n, rd_n, a0;
  logic [7:0] d_in, irr_i, isr_i, poll_vec_i;

  logic [7:0] d_out, icw1_o, icw2_o, icw3_o, icw4_o, imr_o, ocw2_o;
  logic       d_oe, init_pulse, init_done, ocw2_stb, smm_o, poll_ack, seq_err;

  logic [7:0] n_d_out, n_icw1, n_icw2, n_icw3, n_icw4, n_imr, n_ocw2;
  logic       n_d_oe, n_init_pulse, n_init_done, n_ocw2_stb, n_smm, n_poll_ack, n_seq_err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pic_rw_ctrl_seq #(.DW(8), .CASCADE_EN(1), .RR_DEFAULT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .a0(a0),
    .d_in(d_in), .d_out(d_out), .d_oe(d_oe), .irr_i(irr_i), .isr_i(isr_i),
    .poll_vec_i(poll_vec_i), .icw1_o(icw1_o), .icw2_o(icw2_o), .icw3_o(icw3_o),
    .icw4_o(icw4_o), .init_pulse(init_pulse), .init_done(init_done),
    .imr_o(imr_o), .ocw2_o(ocw2_o), .ocw2_stb(ocw2_stb), .smm_o(smm_o),
    .poll_ack(poll_ack), .seq_err(seq_err)
  );

  pic_rw_ctrl_seq #(.DW(8), .CASCADE_EN(0), .RR_DEFAULT(0)) u_dut_nc (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .a0(a0),
    .d_in(d_in), .d_out(n_d_out), .d_oe(n_d_oe), .irr_i(irr_i), .isr_i(isr_i),
    .poll_vec_i(poll_vec_i), .icw1_o(n_icw1), .icw2_o(n_icw2), .icw3_o(n_icw3),
    .icw4_o(n_icw4), .init_pulse(n_init_pulse), .init_done(n_init_done),
    .imr_o(n_imr), .ocw2_o(n_ocw2), .ocw2_stb(n_ocw2_stb), .smm_o(n_smm),
    .poll_ack(n_poll_ack), .seq_err(n_seq_err)
  );

  // sel: 0 icw1, 1 icw2, 2 icw3, 3 icw4, 4 imr, 5 ocw2, 6 smm
  typedef struct {
    logic       is_rd;
    logic       a0;
    logic [7:0] d;
    logic [7:0] irr;
    logic [7:0] isr;
    logic [7:0] pv;
    logic [3:0] sel;
    logic [7:0] exp;
    logic       exp_done;
    logic       exp_err;
    logic       exp_ack;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] observe(input logic [3:0] sel);
    case (sel)
      4'd0: return icw1_o;
      4'd1: return icw2_o;
      4'd2: return icw3_o;
      4'd3: return icw4_o;
      4'd4: return imr_o;
      4'd5: return ocw2_o;
      4'd6: return {7'd0, smm_o};
      default: return 8'hxx;
    endcase
  endfunction

  task automatic addw(input logic wa0, input logic [7:0] wd, input logic [3:0] sel,
                      input logic [7:0] exp, input logic done, input logic err);
    vec_t v;
    v = '{1'b0, wa0, wd, 8'h00, 8'h00, 8'h00, sel, exp, done, err, 1'b0};
    tv.push_back(v);
  endtask

  task automatic addr(input logic ra0, input logic [7:0] irr, input logic [7:0] isr,
                      input logic [7:0] pv, input logic [7:0] exp, input logic ack);
    vec_t v;
    v = '{1'b1, ra0, 8'h00, irr, isr, pv, 4'd0, exp, 1'b0, 1'b0, ack};
    tv.push_back(v);
  endtask

  // Full write cycle; returns at the sample point right after the commit edge
  task automatic bus_write(input logic cs, input logic wa0, input logic [7:0] wd);
    @(negedge clk); cs_n = cs; wr_n = 1'b0; a0 = wa0; d_in = wd;
    @(negedge clk); wr_n = 1'b1;
    @(negedge clk); cs_n = 1'b1;
  endtask

  task automatic bus_read(input logic ra0, output logic oe_before, output logic oe,
                          output logic [7:0] data, output logic ack);
    @(negedge clk); cs_n = 1'b0; rd_n = 1'b0; a0 = ra0;
    oe_before = d_oe;
    @(negedge clk); oe = d_oe; data = d_out; rd_n = 1'b1;
    @(negedge clk); ack = poll_ack; cs_n = 1'b1;
  endtask

  initial begin
    logic       ob, oe, ack;
    logic [7:0] dat;

    rst_n = 1'b0; cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; a0 = 1'b0;
    d_in = 8'h00; irr_i = 8'h00; isr_i = 8'h00; poll_vec_i = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_icw1", icw1_o, 8'h00);
    chk("rst_icw2", icw2_o, 8'h00);
    chk("rst_icw3", icw3_o, 8'h00);
    chk("rst_icw4", icw4_o, 8'h00);
    chk("rst_imr", imr_o, 8'h00);
    chk("rst_ocw2", ocw2_o, 8'h00);
    chk("rst_done", {7'd0, init_done}, 8'h00);
    chk("rst_oe", {7'd0, d_oe}, 8'h00);
    chk("rst_smm", {7'd0, smm_o}, 8'h00);
    chk("rst_pulses", {4'd0, init_pulse, ocw2_stb, poll_ack, seq_err}, 8'h00);

    // Directed vector table
    addr(1'b0, 8'h5A, 8'hA5, 8'h00, 8'h5A, 1'b0);           // reset read select = IRR
    addw(1'b0, 8'h13, 4'd0, 8'h13, 1'b0, 1'b0);             // ICW1 single, IC4
    addw(1'b1, 8'h20, 4'd1, 8'h20, 1'b0, 1'b0);             // ICW2, ICW3 skipped
    addw(1'b1, 8'h01, 4'd3, 8'h01, 1'b1, 1'b0);             // ICW4 -> done
    addw(1'b1, 8'hF0, 4'd4, 8'hF0, 1'b1, 1'b0);             // OCW1
    addr(1'b1, 8'h55, 8'h04, 8'h00, 8'hF0, 1'b0);           // read IMR
    addw(1'b0, 8'h0B, 4'd6, 8'h00, 1'b1, 1'b0);             // OCW3 read ISR
    addr(1'b0, 8'h55, 8'h04, 8'h00, 8'h04, 1'b0);
    addw(1'b0, 8'h0A, 4'd6, 8'h00, 1'b1, 1'b0);             // OCW3 read IRR
    addr(1'b0, 8'h55, 8'h04, 8'h00, 8'h55, 1'b0);
    addw(1'b0, 8'h0C, 4'd6, 8'h00, 1'b1, 1'b0);             // OCW3 poll
    addr(1'b0, 8'h55, 8'h04, 8'h83, 8'h83, 1'b1);           // poll read
    addr(1'b0, 8'h55, 8'h04, 8'h83, 8'h55, 1'b0);           // back to IRR
    addw(1'b0, 8'h68, 4'd6, 8'h01, 1'b1, 1'b0);             // OCW3 ESMM+SMM
    addw(1'b0, 8'h20, 4'd5, 8'h20, 1'b1, 1'b0);             // OCW2 EOI
    addw(1'b0, 8'h11, 4'd4, 8'h00, 1'b0, 1'b0);             // ICW1 cascade: IMR cleared
    addw(1'b1, 8'h08, 4'd1, 8'h08, 1'b0, 1'b0);
    addw(1'b1, 8'h04, 4'd2, 8'h04, 1'b0, 1'b0);             // ICW3
    addw(1'b1, 8'h1D, 4'd3, 8'h1D, 1'b1, 1'b0);             // ICW4 -> done
    addw(1'b0, 8'h16, 4'd0, 8'h16, 1'b0, 1'b0);             // ICW1 single, no IC4
    addw(1'b0, 8'h05, 4'd1, 8'h00, 1'b0, 1'b1);             // illegal in WAIT_ICW2
    addw(1'b1, 8'h40, 4'd1, 8'h40, 1'b1, 1'b0);             // ICW2 -> done

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].is_rd) begin
        irr_i = tv[i].irr; isr_i = tv[i].isr; poll_vec_i = tv[i].pv;
        bus_read(tv[i].a0, ob, oe, dat, ack);
        chk($sformatf("vec%0d_oe_lat", i), {7'd0, ob}, 8'h00);
        chk($sformatf("vec%0d_oe", i), {7'd0, oe}, 8'h01);
        chk($sformatf("vec%0d_dout", i), dat, tv[i].exp);
        chk($sformatf("vec%0d_pack", i), {7'd0, ack}, {7'd0, tv[i].exp_ack});
      end else begin
        bus_write(1'b0, tv[i].a0, tv[i].d);
        chk($sformatf("vec%0d_field", i), observe(tv[i].sel), tv[i].exp);
        chk($sformatf("vec%0d_done", i), {7'd0, init_done}, {7'd0, tv[i].exp_done});
        chk($sformatf("vec%0d_err", i), {7'd0, seq_err}, {7'd0, tv[i].exp_err});
      end
    end

    // OCW2 strobe lasts exactly one clock
    bus_write(1'b0, 1'b0, 8'h20);
    chk("ocw2_stb_hi", {7'd0, ocw2_stb}, 8'h01);
    @(negedge clk);
    chk("ocw2_stb_lo", {7'd0, ocw2_stb}, 8'h00);

    // Simultaneous write and read: write wins, no drive
    @(negedge clk); cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b0; a0 = 1'b1; d_in = 8'h3C;
    @(negedge clk);
    chk("wr_rd_oe0", {7'd0, d_oe}, 8'h00);
    wr_n = 1'b1; rd_n = 1'b1;
    @(negedge clk);
    chk("wr_rd_oe1", {7'd0, d_oe}, 8'h00);
    chk("wr_rd_imr", imr_o, 8'h3C);
    cs_n = 1'b1;

    // Deselected write: no commit, no error
    bus_write(1'b1, 1'b1, 8'h99);
    chk("cs_hi_imr", imr_o, 8'h3C);
    chk("cs_hi_err", {7'd0, seq_err}, 8'h00);

    // ICW1 pulse and restart from WAIT_ICW3
    bus_write(1'b0, 1'b0, 8'h11);
    chk("ipulse_hi", {7'd0, init_pulse}, 8'h01);
    @(negedge clk);
    chk("ipulse_lo", {7'd0, init_pulse}, 8'h00);
    bus_write(1'b0, 1'b1, 8'h08);
    bus_write(1'b0, 1'b0, 8'h11);
    chk("restart_icw2", icw2_o, 8'h00);
    chk("restart_pulse", {7'd0, init_pulse}, 8'h01);
    chk("restart_done", {7'd0, init_done}, 8'h00);

    // Cascade disabled: ICW3 never expected
    bus_write(1'b0, 1'b0, 8'h11);
    bus_write(1'b0, 1'b1, 8'h08);
    bus_write(1'b0, 1'b1, 8'h1D);
    chk("nc_done", {7'd0, n_init_done}, 8'h01);
    chk("nc_icw3", n_icw3, 8'h00);
    chk("nc_icw4", n_icw4, 8'h1D);
    chk("casc_icw3", icw3_o, 8'h1D);
    chk("casc_done", {7'd0, init_done}, 8'h00);

    // Reset during a write: nothing commits afterwards
    @(negedge clk); cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; d_in = 8'h77;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; wr_n = 1'b1;
    @(negedge clk); cs_n = 1'b1;
    chk("rstw_icw4", icw4_o, 8'h00);
    chk("rstw_icw1", icw1_o, 8'h00);
    chk("rstw_done", {7'd0, init_done}, 8'h00);
    chk("rstw_pulses", {4'd0, init_pulse, ocw2_stb, poll_ack, seq_err}, 8'h00);
    bus_write(1'b0, 1'b1, 8'h55);
    chk("uninit_err", {7'd0, seq_err}, 8'h01);
    chk("uninit_icw2", icw2_o, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
